// File: rtl/counter_nb_if.sv
// Signal bundle for one counter_nb stage: control inputs plus count/carry/status outputs.
// The stage itself uses the slave modport; whatever drives it uses master.
interface counter_nb_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             ci;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             oneshot;
    logic [WIDTH-1:0] q;
    logic             rc;
    logic             tc;
    logic             done;

    modport master (
        output en, ci, up, load, d, oneshot,
        input  q, rc, tc, done
    );

    modport slave (
        input  en, ci, up, load, d, oneshot,
        output q, rc, tc, done
    );
endinterface

// File: rtl/counter_nb.sv
// Modulo-MODULUS counter with enable, cascade carry, saturating load and one-shot stop.
// Define COUNTER_NB_UPDOWN_EN to honour bus.up (down counting); otherwise up-only.
module counter_nb #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic        clk,
    input  logic        rst,
    counter_nb_if.slave bus
);

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] adv_val;
    logic             at_term;
    logic             step;

`ifdef COUNTER_NB_UPDOWN_EN
    logic dir_up;
    assign dir_up   = bus.up;
    assign term_val = dir_up ? MAX_VAL : '0;

    always_comb begin
        adv_val = '0;
        if (dir_up) begin
            adv_val = (cnt_q == MAX_VAL) ? '0 : cnt_q + 1'b1;
        end else begin
            adv_val = (cnt_q == '0) ? MAX_VAL : cnt_q - 1'b1;
        end
    end
`else
    logic unused_up;
    assign unused_up = bus.up;
    assign term_val  = MAX_VAL;

    always_comb begin
        adv_val = (cnt_q == MAX_VAL) ? '0 : cnt_q + 1'b1;
    end
`endif

    // Out-of-range load values clamp to the top of the range so q stays legal.
    assign load_val = ({1'b0, bus.d} < MOD_EXT) ? bus.d : MAX_VAL;
    assign at_term  = (cnt_q == term_val);
    assign step     = bus.en & bus.ci & (state_q == RUN);

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        done_d  = done_q;
        if (bus.load) begin
            cnt_d   = load_val;
            state_d = RUN;
            done_d  = 1'b0;
        end else if (step) begin
            if (at_term && bus.oneshot) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                cnt_d = adv_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= RUN;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // rc is purely combinational so a whole chain advances on the same edge.
    assign bus.q    = cnt_q;
    assign bus.tc   = at_term | (state_q == DONE);
    assign bus.rc   = step & at_term;
    assign bus.done = done_q;

endmodule

// File: doc/counter_nb.md
# counter_nb

Parametrised N-bit synchronous counter: the next generation of the 4-bit ripple-carry counter. Adds a configurable modulus, count enable, carry-in for cascading, synchronous parallel load and a one-shot mode. Optional up/down direction. Used as a building block for clock dividers, timers and multi-digit (e.g. BCD) counter chains, where the `rc` of one stage feeds the `ci` of the next.

## Interface
- `WIDTH`, default 4: counter width in bits, 2..16.
- `MODULUS`, default 16: count range 0..MODULUS-1, with 2 ≤ MODULUS ≤ 2^WIDTH.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: count enable.
- `ci` in 1: carry-in for cascading; tie to 1 on the first stage.
- `up` in 1: direction, 1 = up, 0 = down. Used only with `COUNTER_NB_UPDOWN_EN`.
- `load` in 1: synchronous parallel load.
- `d` in WIDTH: load value.
- `oneshot` in 1: 1 = stop at terminal count instead of wrapping.
- `q` out WIDTH: current count.
- `rc` out 1: ripple carry, combinational.
- `tc` out 1: terminal count reached, combinational from `q`/direction.
- `done` out 1: one-shot finished, registered.

## Operation
- State machine with two states, RUN and DONE.
- Terminal value T:
  - counting up: T = MODULUS-1;
  - counting down: T = 0.
- `tc` = (q == T).
- `rc` = en & ci & tc & (state == RUN).
- Priority per rising edge, highest first:
  - **Load** (`load`=1):
    - q ← d if d < MODULUS, else q ← MODULUS-1 (saturate);
    - state ← RUN, done ← 0;
    - applies in RUN and DONE, and regardless of `en`/`ci`.
  - **Advance** (RUN, en & ci):
    - up: q ← (q == MODULUS-1) ? 0 : q+1;
    - down: q ← (q == 0) ? MODULUS-1 : q-1.
  - **One-shot stop** (RUN, en & ci & tc & oneshot): takes the place of the wrap in the advance rule.
    - q holds T;
    - state ← DONE, done ← 1.
  - **Otherwise**: hold.
- DONE:
  - q frozen, rc = 0, tc = 1;
  - leave only via `load` or `rst`;
  - deasserting `oneshot` does not exit DONE.
- Direction change takes effect at the next advancing edge. T and `tc` follow `up` combinationally.
- `q` never leaves 0..MODULUS-1, including after load.

## Timing
- Reset value (asynchronous, immediate): q = 0, state RUN, done = 0. `tc` and `rc` then follow the combinational rules.
- Load latency 1 cycle: `q` shows `d` after the edge where `load`=1.
- Advance latency 1 cycle per enabled edge.
- `rc` is combinational, so a cascaded stage advances on the same edge as the lower stage's wrap. Chain delay is N levels of AND.
- `done` rises on the edge of the terminal advance attempt, not one cycle later.
- Reset mid-count or in DONE returns to 0/RUN immediately. The first advance after `rst` falls is on the next qualifying edge.
- `load` and `rst` together: reset wins.

## Configuration
- Macro: `COUNTER_NB_UPDOWN_EN`.
- Defined: `up` selects direction as described above.
- Undefined: `up` is ignored and the counter is up-only (T = MODULUS-1). No down-count logic is synthesised.

## Test plan
- Reset and free run, WIDTH=4, MODULUS=10:
  - stimulus: rst pulse, en=ci=1, 12 clocks;
  - response: q = 0,1,…,9,0,1; rc=1 only while q=9; tc tracks q=9.
- Cascade of two MODULUS=10 stages as BCD, lower rc → upper ci:
  - stimulus: 105 clocks from reset;
  - response: upper q=0, lower q=5 after clock 105; upper increments exactly on lower 9→0 edges.
- Load priority and saturation:
  - stimulus: load=1, d=7 with en=ci=1;
  - response: q=7, not 8;
  - stimulus: load d=12 with MODULUS=10;
  - response: q=9.
- One-shot, MODULUS=16, oneshot=1:
  - stimulus: load d=13, then 5 enabled clocks;
  - response: q=14,15,15,15,15; done=1 from the edge where q was already 15; rc=0 in DONE;
  - stimulus: load d=0;
  - response: done=0, counting resumes.
- Up/down (macro defined), MODULUS=10:
  - stimulus: from q=1, up=0, 3 clocks;
  - response: q=0,9,8; tc=1 at q=0;
  - stimulus: up=1 at q=8;
  - response: next edge gives q=9.
- Reset mid-operation:
  - stimulus: async rst asserted between edges at q=6, and again while in DONE;
  - response: q=0, done=0 immediately with no clock edge; counting resumes on the first enabled edge after release.
